pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel PWM generator. Successor to the single-channel 4-bit ALU-driven PWM.
//  N_CH channels share one prescaler and one period counter.
//  Duty values are double-buffered, so updates take effect only at a period boundary (glitch-free).
//  Edge-aligned or centre-aligned mode. Sits between ALU/register outputs and the board pins.
// PARAMETERS
//  N_CH     4  number of PWM channels
//  DUTY_W   4  duty/counter width, >=2; MAX = 2**DUTY_W-1
//  PRESC_W  8  prescaler width
// PORTS
//  clk           in   1             system clock, single clock domain
//  rst           in   1             synchronous reset, active-high
//  en            in   1             run enable
//  mode          in   1             0 = edge-aligned, 1 = centre-aligned (shadowed)
//  prescale      in   PRESC_W       tick every prescale+1 clocks
//  duty_in       in   N_CH*DUTY_W   channel i duty = duty_in[i*DUTY_W +: DUTY_W]
//  duty_wr       in   N_CH          per-channel write strobe into shadow register
//  pwm           out  N_CH          PWM outputs (registered)
//  period_start  out  1             1-cycle pulse when a new period begins
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - All registers cleared: pwm=0, period_start=0, counters=0, shadow=0, active=0, mode_act=0, dir=up.
//   - rst has priority over every other input.
//  Prescaler:
//   - pcnt counts 0..prescale; tick=1 when pcnt==prescale, then pcnt<=0.
//   - prescale=0 -> tick every clock.
//   - A prescale change is used immediately. If pcnt>prescale, pcnt<=0 with tick=1.
//  Edge mode:
//   - cnt advances 0,1,...,MAX-1,0 on each tick. Period = MAX ticks.
//  Centre mode:
//   - cnt goes 0 up to MAX-1, then down to 1, then 0. Period = 2*MAX-2 ticks.
//   - dir flips at the turn points.
//  boundary = tick && cnt at last value of period (edge: MAX-1; centre: dir=down && cnt==1).
//  On boundary:
//   - cnt<=0, dir<=up, mode_act<=mode, active[i]<=shadow[i].
//   - period_start=1 in the next cycle only.
//  Shadow write:
//   - duty_wr[i] -> shadow[i]<=duty_in slice.
//   - Write in the same cycle as boundary: active[i] takes duty_in directly (write-through).
//  Output: pwm[i] <= en && (cnt < active[i]). 1-clock latency from cnt.
//   - duty=0 -> constant 0.
//   - duty=MAX -> constant 1.
//   - edge mode: high ticks = d.
//   - centre mode: high ticks = 2d-1 for 1<=d<=MAX-1, and 2*MAX-2 for d=MAX; pulse is symmetric about cnt=0.
//  en=0:
//   - pcnt, cnt and dir held at 0/up; pwm=0; period_start=0.
//   - active<=shadow and mode_act<=mode every cycle.
//   - Re-enable starts a fresh period from cnt=0 with no period_start pulse for it.
//   - Deasserting en mid-period aborts the period; outputs go low next cycle.
//  Writing shadow mid-period never alters the current period's waveform.
// STRUCTURE
//  pwm_pkg:
//   - typedef enum logic {PWM_EDGE, PWM_CENTRE} pwm_mode_e;
//   - typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e.
//  Sub-module pwm_prescaler (clk, rst, en, prescale -> tick), one instance.
//  Channel compare: generate loop over N_CH; counter, dir and boundary logic shared.
// TESTING
//  T1 Reset:
//   - rst held 3 clocks mid-run -> pwm=0 and period_start=0 on the next edge.
//   - cnt restarts at 0 after release.
//  T2 Edge, prescale=0, DUTY_W=4:
//   - duties 0,6,15,8 -> per 15 clocks, ch0 never high, ch1 high 6, ch2 always high, ch3 high 8.
//   - period_start every 15 clocks.
//  T3 Double buffer:
//   - write duty 3 at cnt=5 while active is 10 -> current period high 10.
//   - next period high 3; write coinciding with boundary takes effect immediately.
//  T4 Centre mode, prescale=0, duty 4 -> period 28 clocks, high 7, centred on the cnt=0 point.
//  T5 Prescale=3:
//   - tick every 4 clocks; edge period = 60 clocks; duty 5 -> high 20 clocks.
//   - mode change mid-period applies only after period_start.
//  T6 en toggled low mid-period -> pwm low next cycle; re-enable restarts from cnt=0 with new shadow duties.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: counting mode and centre-mode count direction.
// Pure type/constant package; no logic, no timing.
package pwm_pkg;

   typedef enum logic {PWM_EDGE, PWM_CENTRE} pwm_mode_e;
   typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: tick is a combinational pulse from the count register, high every prescale+1 clocks.
// Zero latency from the registered count; no backpressure, en=0 holds the count at 0.
module pwm_prescaler #(
   parameter int unsigned PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] prescale,
   output logic               tick
);

   localparam logic [PRESC_W-1:0] C_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

   logic [PRESC_W-1:0] r_pcnt;
   logic               w_wrap;

   // >= rather than == so a prescale shrunk below the live count wraps at once
   assign w_wrap = (r_pcnt >= prescale);
   assign tick   = en && w_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (!en || w_wrap) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + C_ONE;
      end
   end

endmodule

// File: rtl/pwm_multi_ch.sv
// N_CH PWM channels on one shared period counter (edge or centre aligned), duties double-buffered to the period boundary.
// pwm and period_start are registered one clock after the counter; no backpressure, duty writes are always accepted.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned DUTY_W  = 4,
   parameter int unsigned PRESC_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic [PRESC_W-1:0]       prescale,
   input  logic [N_CH*DUTY_W-1:0]   duty_in,
   input  logic [N_CH-1:0]          duty_wr,
   output logic [N_CH-1:0]          pwm,
   output logic                     period_start
);

   localparam logic [DUTY_W-1:0] C_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};
   localparam logic [DUTY_W-1:0] C_TOP = {{(DUTY_W-1){1'b1}}, 1'b0};

   logic              w_tick;
   logic              w_last;
   logic              w_boundary;
   logic [DUTY_W-1:0] r_cnt;
   pwm_dir_e          r_dir;
   pwm_mode_e         r_mode_act;
   logic              r_period_start;

   pwm_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .prescale (prescale),
      .tick     (w_tick)
   );

   always_comb begin
      w_last = 1'b0;
      if (r_mode_act == PWM_EDGE) begin
         w_last = (r_cnt == C_TOP);
      end else begin
         w_last = (r_dir == DIR_DOWN) && (r_cnt == C_ONE);
      end
      w_boundary = w_tick && w_last;
   end

   // Shared period counter; en=0 parks it so re-enable starts a clean period
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt          <= '0;
         r_dir          <= DIR_UP;
         r_mode_act     <= PWM_EDGE;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_boundary;
         if (!en || w_boundary) begin
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_mode_act <= pwm_mode_e'(mode);
         end else if (w_tick) begin
            if (r_mode_act == PWM_EDGE) begin
               r_cnt <= r_cnt + C_ONE;
            end else if (r_dir == DIR_UP) begin
               if (r_cnt == C_TOP) begin
                  r_dir <= DIR_DOWN;
                  r_cnt <= r_cnt - C_ONE;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end else begin
               r_cnt <= r_cnt - C_ONE;
            end
         end
      end
   end

   assign period_start = r_period_start;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [DUTY_W-1:0] w_duty;
      logic [DUTY_W-1:0] r_shadow;
      logic [DUTY_W-1:0] r_active;
      logic              r_pwm;

      assign w_duty = duty_in[i*DUTY_W +: DUTY_W];

      // A write landing on the boundary bypasses the shadow so it is not a period late
      always_ff @(posedge clk) begin
         if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
         end else begin
            if (duty_wr[i]) begin
               r_shadow <= w_duty;
            end
            if (!en) begin
               r_active <= r_shadow;
            end else if (w_boundary) begin
               r_active <= duty_wr[i] ? w_duty : r_shadow;
            end
            r_pwm <= en && (r_cnt < r_active);
         end
      end

      assign pwm[i] = r_pwm;
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: per-period waveform measurements compared against a queue of expected shapes.
// Expected period length, high count and leading high run per channel are derived from the duty values.
module tb_pwm_multi_ch;

   localparam int N_CH    = 4;
   localparam int DUTY_W  = 4;
   localparam int PRESC_W = 8;
   localparam int MAX     = 15;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   en;
   logic                   mode;
   logic [PRESC_W-1:0]     prescale;
   logic [N_CH*DUTY_W-1:0] duty_in;
   logic [N_CH-1:0]        duty_wr;
   logic [N_CH-1:0]        pwm;
   logic                   period_start;

   always #5 clk = ~clk;

   pwm_multi_ch #(
      .N_CH    (N_CH),
      .DUTY_W  (DUTY_W),
      .PRESC_W (PRESC_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .prescale     (prescale),
      .duty_in      (duty_in),
      .duty_wr      (duty_wr),
      .pwm          (pwm),
      .period_start (period_start)
   );

   typedef struct packed {
      logic [N_CH-1:0][15:0] lead;
      logic [N_CH-1:0][15:0] hi;
      logic [15:0]           len;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_len;
   int   m_hi   [N_CH];
   int   m_lead [N_CH];

   function automatic logic [N_CH*DUTY_W-1:0] dv(input int d0, input int d1, input int d2, input int d3);
      return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
   endfunction

   // Expected shape of one period: edge high = d ticks, centre high = 2d-1 ticks (whole period at MAX)
   function automatic exp_t mk_exp(input logic cm, input int ps, input logic [N_CH*DUTY_W-1:0] duties);
      exp_t e;
      int   d;
      int   t;
      e = '0;
      t = ps + 1;
      e.len = cm ? 16'((2*MAX-2)*t) : 16'(MAX*t);
      for (int i = 0; i < N_CH; i++) begin
         d = int'(duties[i*DUTY_W +: DUTY_W]);
         if (!cm) begin
            e.hi[i]   = 16'(d*t);
            e.lead[i] = 16'(d*t);
         end else if (d == 0) begin
            e.hi[i]   = 16'd0;
            e.lead[i] = 16'd0;
         end else if (d == MAX) begin
            e.hi[i]   = e.len;
            e.lead[i] = e.len;
         end else begin
            e.hi[i]   = 16'((2*d-1)*t);
            e.lead[i] = 16'(d*t);
         end
      end
      return e;
   endfunction

   // Samples one period: from the cycle after a period start up to and including the next period_start
   task automatic measure();
      logic [N_CH-1:0] open;
      logic            done;
      m_len = 0;
      open  = '1;
      done  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         m_hi[i]   = 0;
         m_lead[i] = 0;
      end
      while (!done) begin
         @(negedge clk);
         m_len++;
         for (int i = 0; i < N_CH; i++) begin
            if (pwm[i]) begin
               m_hi[i]++;
               if (open[i]) m_lead[i]++;
            end else begin
               open[i] = 1'b0;
            end
         end
         if (period_start) begin
            done = 1'b1;
         end else if (m_len >= 400) begin
            checks++;
            errors++;
            $display("FAIL measure_timeout: no period_start after %0d cycles, required one", m_len);
            done = 1'b1;
         end
      end
   endtask

   task automatic write_at(input int offset, input logic [N_CH-1:0] mask, input logic [N_CH*DUTY_W-1:0] vec);
      repeat (offset) @(negedge clk);
      duty_in = vec;
      duty_wr = mask;
      @(negedge clk);
      duty_wr = '0;
   endtask

   task automatic program_run(input logic m, input int ps, input logic [N_CH*DUTY_W-1:0] duties);
      en       = 1'b0;
      mode     = m;
      prescale = 8'(ps);
      duty_in  = duties;
      duty_wr  = '1;
      @(negedge clk);
      duty_wr  = '0;
      repeat (2) @(negedge clk);
      en       = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst      = 1'b1;
      en       = 1'b0;
      mode     = 1'b0;
      prescale = '0;
      duty_in  = '0;
      duty_wr  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (pwm !== 4'h0) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b expected 0", period_start); end
      rst = 1'b0;
      program_run(1'b0, 0, dv(15, 15, 15, 15));
      repeat (7) @(negedge clk);
      checks++;
      if (pwm !== 4'hF) begin errors++; $display("FAIL reset_prerun_pwm: got %b expected 1111", pwm); end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (pwm !== 4'h0) begin errors++; $display("FAIL reset_mid_pwm[%0d]: got %b expected 0000", c, pwm); end
         checks++;
         if (period_start !== 1'b0) begin errors++; $display("FAIL reset_mid_ps[%0d]: got %b expected 0", c, period_start); end
      end
      rst = 1'b0;
      sb.push_back(mk_exp(1'b0, 0, dv(0, 0, 0, 0)));
      measure();
      e = sb.pop_front();
      checks++;
      if (m_len !== int'(e.len)) begin errors++; $display("FAIL reset_restart_len: got %0d expected %0d", m_len, e.len); end
      for (int i = 0; i < N_CH; i++) begin
         checks++;
         if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL reset_restart_hi ch%0d: got %0d expected %0d", i, m_hi[i], e.hi[i]); end
      end
   endtask

   task automatic test_edge();
      exp_t e;
      program_run(1'b0, 0, dv(0, 6, 15, 8));
      repeat (3) sb.push_back(mk_exp(1'b0, 0, dv(0, 6, 15, 8)));
      for (int p = 0; p < 3; p++) begin
         measure();
         e = sb.pop_front();
         checks++;
         if (m_len !== int'(e.len)) begin errors++; $display("FAIL edge_len p%0d: got %0d expected %0d", p, m_len, e.len); end
         for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL edge_hi p%0d ch%0d: got %0d expected %0d", p, i, m_hi[i], e.hi[i]); end
            checks++;
            if (m_lead[i] !== int'(e.lead[i])) begin errors++; $display("FAIL edge_lead p%0d ch%0d: got %0d expected %0d", p, i, m_lead[i], e.lead[i]); end
         end
      end
   endtask

   task automatic test_double_buffer();
      exp_t e;
      program_run(1'b0, 0, dv(10, 10, 10, 10));
      sb.push_back(mk_exp(1'b0, 0, dv(10, 10, 10, 10)));
      sb.push_back(mk_exp(1'b0, 0, dv(10, 3, 10, 10)));
      sb.push_back(mk_exp(1'b0, 0, dv(10, 7, 10, 12)));
      for (int p = 0; p < 3; p++) begin
         if (p == 0) begin
            fork
               measure();
               write_at(5, 4'b0010, dv(0, 3, 0, 0));
            join
         end else if (p == 1) begin
            fork
               measure();
               write_at(14, 4'b1010, dv(0, 7, 0, 12));
            join
         end else begin
            measure();
         end
         e = sb.pop_front();
         checks++;
         if (m_len !== int'(e.len)) begin errors++; $display("FAIL dbuf_len p%0d: got %0d expected %0d", p, m_len, e.len); end
         for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL dbuf_hi p%0d ch%0d: got %0d expected %0d", p, i, m_hi[i], e.hi[i]); end
         end
      end
   endtask

   task automatic test_centre();
      exp_t e;
      program_run(1'b1, 0, dv(4, 0, 15, 1));
      repeat (2) sb.push_back(mk_exp(1'b1, 0, dv(4, 0, 15, 1)));
      for (int p = 0; p < 2; p++) begin
         measure();
         e = sb.pop_front();
         checks++;
         if (m_len !== int'(e.len)) begin errors++; $display("FAIL centre_len p%0d: got %0d expected %0d", p, m_len, e.len); end
         for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL centre_hi p%0d ch%0d: got %0d expected %0d", p, i, m_hi[i], e.hi[i]); end
            checks++;
            if (m_lead[i] !== int'(e.lead[i])) begin errors++; $display("FAIL centre_lead p%0d ch%0d: got %0d expected %0d", p, i, m_lead[i], e.lead[i]); end
         end
      end
   endtask

   task automatic test_prescale();
      exp_t e;
      program_run(1'b0, 3, dv(5, 0, 10, 15));
      sb.push_back(mk_exp(1'b0, 3, dv(5, 0, 10, 15)));
      sb.push_back(mk_exp(1'b1, 3, dv(5, 0, 10, 15)));
      for (int p = 0; p < 2; p++) begin
         if (p == 0) begin
            fork
               measure();
               begin
                  repeat (30) @(negedge clk);
                  mode = 1'b1;
               end
            join
         end else begin
            measure();
         end
         e = sb.pop_front();
         checks++;
         if (m_len !== int'(e.len)) begin errors++; $display("FAIL presc_len p%0d: got %0d expected %0d", p, m_len, e.len); end
         for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL presc_hi p%0d ch%0d: got %0d expected %0d", p, i, m_hi[i], e.hi[i]); end
            checks++;
            if (m_lead[i] !== int'(e.lead[i])) begin errors++; $display("FAIL presc_lead p%0d ch%0d: got %0d expected %0d", p, i, m_lead[i], e.lead[i]); end
         end
      end
   endtask

   task automatic test_enable();
      exp_t e;
      program_run(1'b0, 0, dv(15, 4, 15, 0));
      repeat (20) @(negedge clk);
      checks++;
      if (pwm !== 4'b0101) begin errors++; $display("FAIL en_prerun_pwm: got %b expected 0101", pwm); end
      en      = 1'b0;
      duty_in = dv(3, 9, 0, 15);
      duty_wr = '1;
      @(negedge clk);
      duty_wr = '0;
      checks++;
      if (pwm !== 4'h0) begin errors++; $display("FAIL en_off_pwm: got %b expected 0000", pwm); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("FAIL en_off_ps: got %b expected 0", period_start); end
      repeat (3) @(negedge clk);
      en = 1'b1;
      sb.push_back(mk_exp(1'b0, 0, dv(3, 9, 0, 15)));
      measure();
      e = sb.pop_front();
      checks++;
      if (m_len !== int'(e.len)) begin errors++; $display("FAIL en_restart_len: got %0d expected %0d", m_len, e.len); end
      for (int i = 0; i < N_CH; i++) begin
         checks++;
         if (m_hi[i] !== int'(e.hi[i])) begin errors++; $display("FAIL en_restart_hi ch%0d: got %0d expected %0d", i, m_hi[i], e.hi[i]); end
         checks++;
         if (m_lead[i] !== int'(e.lead[i])) begin errors++; $display("FAIL en_restart_lead ch%0d: got %0d expected %0d", i, m_lead[i], e.lead[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_double_buffer();
      test_centre();
      test_prescale();
      test_enable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
